// File: rtl/dm_bus_access_pkg.sv
// Shared types for the MEM-stage data-memory bus access unit:
// access-size encodings, FSM states and the latched bus command.
package dm_bus_access_pkg;

    localparam logic [31:0] ADDR_LO_DEF = 32'h0000_0000;
    localparam logic [31:0] ADDR_HI_DEF = 32'h0000_2FFF;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        MT_NONE = 2'b00,
        MT_BYTE = 2'b01,
        MT_HALF = 2'b10,
        MT_WORD = 2'b11
    } mtype_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/dm_store_align.sv
// Combinational lane builder: byte enables, replicated store data and
// natural-alignment check for one access.
module dm_store_align
    import dm_bus_access_pkg::*;
(
    input  logic [1:0]  mtype,
    input  logic [1:0]  offset,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        aligned
);

    always_comb begin
        be         = 4'b0000;
        lane_wdata = 32'h0;
        aligned    = 1'b0;
        case (mtype_e'(mtype))
            MT_BYTE: begin
                be         = 4'b0001 << offset;
                lane_wdata = {4{wdata[7:0]}};
                aligned    = 1'b1;
            end
            MT_HALF: begin
                be         = offset[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                aligned    = ~offset[0];
            end
            MT_WORD: begin
                be         = 4'b1111;
                lane_wdata = wdata;
                aligned    = (offset == 2'b00);
            end
            default: ;
        endcase
        // Loads always fetch the whole word; the load extender picks the lanes.
        if (!we) begin
            be         = 4'b1111;
            lane_wdata = 32'h0;
        end
    end

endmodule

// File: rtl/dm_bus_access.sv
// MEM-stage data-memory access unit: validates a load/store, runs a req/ack
// handshake with timeout on the word bus and stalls the pipeline until done.
module dm_bus_access
    import dm_bus_access_pkg::*;
#(
    parameter logic [31:0] ADDR_LO = ADDR_LO_DEF,
    parameter logic [31:0] ADDR_HI = ADDR_HI_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [31:0] addr,
    input  logic [1:0]  M_type,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        adel,
    output logic        ades,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e      state, state_d;
    bus_cmd_t    cmd, cmd_d;
    logic [CW-1:0] ctr, ctr_d;
    logic        req_d, err_d;
    logic [31:0] rdata_d;
    logic        stall_c;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        aligned;
    logic        in_lo, in_hi;
    logic        access, legal;

    dm_store_align u_align (
        .mtype      (M_type),
        .offset     (addr[1:0]),
        .we         (mem_we),
        .wdata      (wdata),
        .be         (lane_be),
        .lane_wdata (lane_wdata),
        .aligned    (aligned)
    );

    // A bound at the edge of the address space is always satisfied.
    if (ADDR_LO == 32'h0) begin : g_lo_open
        assign in_lo = 1'b1;
    end else begin : g_lo
        assign in_lo = (addr >= ADDR_LO);
    end
    if (ADDR_HI == 32'hFFFF_FFFF) begin : g_hi_open
        assign in_hi = 1'b1;
    end else begin : g_hi
        assign in_hi = (addr <= ADDR_HI);
    end

    assign access = mem_en && (mtype_e'(M_type) != MT_NONE);
    assign legal  = access && aligned && in_lo && in_hi;

    always_comb begin
        state_d = state;
        cmd_d   = cmd;
        ctr_d   = ctr;
        req_d   = bus_req;
        rdata_d = rdata;
        err_d   = 1'b0;
        stall_c = 1'b0;
        adel    = 1'b0;
        ades    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (legal) begin
                    cmd_d   = '{we: mem_we, addr: addr[31:2], be: lane_be, wdata: lane_wdata};
                    req_d   = 1'b1;
                    ctr_d   = '0;
                    stall_c = 1'b1;
                    state_d = ST_REQ;
                end else if (access) begin
                    adel = ~mem_we;
                    ades = mem_we;
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                if (bus_ack) begin
                    req_d = 1'b0;
                    if (!cmd.we) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = ST_DONE;
                end else if (ctr == CW'(TIMEOUT - 1)) begin
                    req_d   = 1'b0;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ctr_d = ctr + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset must release the pipeline immediately, even with a request held upstream.
    assign stall = stall_c & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cmd     <= '0;
            ctr     <= '0;
            bus_req <= 1'b0;
            bus_err <= 1'b0;
            rdata   <= 32'h0;
        end else begin
            state   <= state_d;
            cmd     <= cmd_d;
            ctr     <= ctr_d;
            bus_req <= req_d;
            bus_err <= err_d;
            rdata   <= rdata_d;
        end
    end

    assign bus_we    = cmd.we;
    assign bus_addr  = cmd.addr;
    assign bus_be    = cmd.be;
    assign bus_wdata = cmd.wdata;

endmodule

// File: tb/tb_dm_bus_access.sv
// Self-checking bench for dm_bus_access: directed scenarios plus random
// accesses checked against an arithmetic model of the access rules.
module tb_dm_bus_access;

    localparam logic [31:0] ADDR_HI = 32'h0000_2FFF;
    localparam int          TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] addr;
    logic [1:0]  M_type;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        adel;
    logic        ades;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks;
    int errors;
    logic [31:0] exp_rdata;

    dm_bus_access dut (
        .clk       (clk),
        .reset     (reset),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .addr      (addr),
        .M_type    (M_type),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .adel      (adel),
        .ades      (ades),
        .bus_err   (bus_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Access rules as arithmetic: size in bytes, modulo alignment, and lane
    // replication by multiplying the masked data with a repeating-ones pattern.
    function automatic void model(input logic we, input logic [31:0] a, input logic [1:0] mt,
                                  input logic [31:0] wd, output logic legal,
                                  output logic [3:0] be, output logic [31:0] lane);
        logic [31:0] size;
        logic [31:0] mask;
        logic [31:0] rep;
        logic [31:0] be_full;
        size = (mt == 2'd3) ? 32'd4 : {30'd0, mt};
        if (mt == 2'd0) begin
            legal = 1'b0;
            size  = 32'd1;
        end else begin
            legal = ((a % size) == 32'd0) && (a <= ADDR_HI);
        end
        be_full = ((32'd1 << size) - 32'd1) << (a % 32'd4);
        be   = we ? be_full[3:0] : 4'hF;
        mask = (size == 32'd4) ? 32'hFFFF_FFFF : ((32'd1 << (32'd8 * size)) - 32'd1);
        rep  = (size == 32'd1) ? 32'h0101_0101 : ((size == 32'd2) ? 32'h0001_0001 : 32'h1);
        lane = (wd & mask) * rep;
    endfunction

    // One access from presentation through retirement; ack_after < 0 means the bus never answers.
    task automatic access(input logic en, input logic we, input logic [31:0] a, input logic [1:0] mt,
                          input logic [31:0] wd, input int ack_after, input logic [31:0] brd);
        logic        legal;
        logic [3:0]  ebe;
        logic [31:0] elane;
        int          ncyc;
        logic        tmo;
        model(we, a, mt, wd, legal, ebe, elane);
        legal = legal && en;
        @(negedge clk);
        mem_en = en; mem_we = we; addr = a; M_type = mt; wdata = wd; bus_ack = 1'b0;
        #1;
        if (!legal) begin
            chk("nolegal_stall", 32'(stall), 32'd0);
            chk("adel", 32'(adel), 32'(en && mt != 2'd0 && !we));
            chk("ades", 32'(ades), 32'(en && mt != 2'd0 && we));
            @(posedge clk); #1;
            chk("nolegal_req", 32'(bus_req), 32'd0);
            chk("nolegal_stall_hold", 32'(stall), 32'd0);
            chk("nolegal_rdata", rdata, exp_rdata);
            mem_en = 1'b0;
            return;
        end
        chk("idle_stall", 32'(stall), 32'd1);
        chk("idle_err", 32'({adel, ades}), 32'd0);
        tmo  = (ack_after < 0) || (ack_after >= TIMEOUT);
        ncyc = tmo ? TIMEOUT : ack_after + 1;
        @(posedge clk); #1;
        for (int k = 0; k < ncyc; k++) begin
            chk("req", 32'(bus_req), 32'd1);
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_we", 32'(bus_we), 32'(we));
            chk("req_addr", 32'(bus_addr), a >> 2);
            chk("req_be", 32'(bus_be), 32'(ebe));
            if (we) chk("req_wdata", bus_wdata, elane);
            if (k == ack_after) begin
                bus_ack = 1'b1;
                bus_rdata = brd;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_rdata = $urandom;
        end
        if (tmo) exp_rdata = 32'h0;
        else if (!we) exp_rdata = brd;
        chk("done_req", 32'(bus_req), 32'd0);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_buserr", 32'(bus_err), 32'(tmo));
        chk("done_rdata", rdata, exp_rdata);
        mem_en = 1'b0;
        @(posedge clk); #1;
        chk("after_buserr", 32'(bus_err), 32'd0);
        chk("after_stall", 32'(stall), 32'd0);
        chk("after_rdata", rdata, exp_rdata);
    endtask

    initial begin
        checks = 0; errors = 0; exp_rdata = 32'h0;
        reset = 1'b1; mem_en = 1'b0; mem_we = 1'b0; addr = 32'h0; M_type = 2'b00;
        wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_flags", 32'({adel, ades, bus_err, bus_req, bus_we}), 32'd0);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_wdata", bus_wdata, 32'h0);
        @(negedge clk); reset = 1'b0;

        // Directed scenarios.
        access(1'b1, 1'b0, 32'h100, 2'b11, 32'h0, 0, 32'hDEAD_BEEF);
        access(1'b1, 1'b1, 32'h203, 2'b01, 32'h1234_56AB, 1, 32'h5555_5555);
        access(1'b1, 1'b1, 32'h202, 2'b10, 32'h0000_BEEF, 2, 32'h0);
        access(1'b1, 1'b0, 32'h201, 2'b10, 32'h0, 0, 32'h0);
        access(1'b1, 1'b1, 32'h3000, 2'b11, 32'hCAFE_F00D, 0, 32'h0);
        access(1'b1, 1'b0, 32'h2FFC, 2'b11, 32'h0, 3, 32'h0BAD_CAFE);
        access(1'b1, 1'b0, 32'h2FFF, 2'b01, 32'h0, 0, 32'h7777_1234);
        access(1'b1, 1'b0, 32'h80, 2'b11, 32'h0, -1, 32'h0);
        access(1'b1, 1'b0, 32'h84, 2'b11, 32'h0, 0, 32'h1357_9BDF);
        access(1'b1, 1'b1, 32'h10, 2'b00, 32'h0, 0, 32'h0);
        access(1'b0, 1'b1, 32'h11, 2'b10, 32'h0, 0, 32'h0);

        // Reset in the middle of a pending load.
        @(negedge clk);
        mem_en = 1'b1; mem_we = 1'b0; addr = 32'h40; M_type = 2'b11;
        @(posedge clk); #1;
        chk("mid_req", 32'(bus_req), 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        exp_rdata = 32'h0;
        chk("arst_req", 32'(bus_req), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        chk("arst_rdata", rdata, exp_rdata);
        @(negedge clk);
        reset = 1'b0; mem_en = 1'b0;
        access(1'b1, 1'b0, 32'h44, 2'b11, 32'h0, 1, 32'hA5A5_0F0F);

        // Random accesses against the model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra;
            logic [1:0]  rmt;
            ra  = $urandom_range(32'h3100, 0);
            rmt = 2'($urandom_range(3, 0));
            if ($urandom_range(2, 0) != 0) ra = ra & 32'hFFFF_FFFC;
            access(($urandom_range(7, 0) != 0), 1'($urandom_range(1, 0)), ra, rmt, $urandom,
                   ($urandom_range(9, 0) == 0) ? -1 : int'($urandom_range(3, 0)), $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
